// File: rtl/msdf_mul_sequencer_if.sv
// Control bundle between the MSDF multiplier sequencer and its surroundings.
// Latency: n/a (wires only).
// Backpressure: in_valid from the master can stall the slave when the stall build is used.
//
// Modports:
//   master - system side: drives start/in_valid, observes datapath controls and status.
//   slave  - sequencer side: receives start/in_valid, drives controls and status.
interface msdf_mul_sequencer_if #(
    parameter int CW = 4
);
    logic          start;
    logic          in_valid;
    logic          clear_regs;
    logic          load_REG_WC;
    logic          load_REG_WS;
    logic          load_PJ;
    logic          digit_req;
    logic          ready_Zj;
    logic [CW-1:0] digit_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, in_valid,
        input  clear_regs, load_REG_WC, load_REG_WS, load_PJ,
        input  digit_req, ready_Zj, digit_idx, busy, done
    );

    modport slave (
        input  start, in_valid,
        output clear_regs, load_REG_WC, load_REG_WS, load_PJ,
        output digit_req, ready_Zj, digit_idx, busy, done
    );
endinterface

// File: rtl/msdf_mul_sequencer.sv
// Run-level sequencer for the MSDF serial-parallel online multiplier: one start -> N digits in, N digits out.
// Latency: INIT (1) + RUN (N+DELTA, plus stall cycles) + DONE (1); first product digit DELTA RUN cycles after the first operand digit.
// Backpressure: start is ignored while busy; with MSDF_STALL_EN, in_valid=0 freezes the run while operand digits are still due.
//
// Optional feature macro: MSDF_STALL_EN (operand stall on in_valid). Default build ignores in_valid.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset; aborts any run
//   bus  - slave modport of msdf_mul_sequencer_if:
//          start/in_valid in; clear_regs, load_REG_WC/WS, load_PJ, digit_req,
//          ready_Zj, digit_idx, busy, done out
module msdf_mul_sequencer #(
    parameter int N     = 9,
    parameter int DELTA = 3,
    parameter int CW    = $clog2(N + DELTA + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    msdf_mul_sequencer_if.slave   bus
);

    localparam int            LAST   = N + DELTA - 1;
    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] D_C    = CW'(DELTA);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          advance;

    // A RUN cycle advances the datapath unless it is waiting for an operand
    // digit. Once all N operand digits are in (cnt>=N) the tail never stalls.
`ifdef MSDF_STALL_EN
    always_comb begin
        advance = (state == RUN) && ((cnt >= N_C) || bus.in_valid);
    end
`else
    logic unused_in_valid;
    assign unused_in_valid = bus.in_valid;

    always_comb begin
        advance = (state == RUN);
    end
`endif

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                cnt_nxt   = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (advance) begin
                    if (cnt == LAST_C) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from state/cnt (and advance for the datapath strobes).
    always_comb begin
        bus.clear_regs  = 1'b0;
        bus.load_REG_WC = 1'b0;
        bus.load_REG_WS = 1'b0;
        bus.load_PJ     = 1'b0;
        bus.digit_req   = 1'b0;
        bus.ready_Zj    = 1'b0;
        bus.digit_idx   = '0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (state)
            INIT: begin
                bus.clear_regs = 1'b1;
                bus.busy       = 1'b1;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (advance) begin
                    bus.load_REG_WC = 1'b1;
                    bus.load_REG_WS = 1'b1;
                    if (cnt < N_C) begin
                        bus.digit_req = 1'b1;
                        bus.load_PJ   = 1'b1;
                    end
                    // The subtraction is only taken when cnt>=DELTA, so
                    // digit_idx cannot underflow even when DELTA>=N.
                    if (cnt >= D_C) begin
                        bus.ready_Zj  = 1'b1;
                        bus.digit_idx = cnt - D_C;
                    end
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // The counter must stay inside the run window, and done is a pulse.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= LAST_C);
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst) bus.done |=> !bus.done);

endmodule

// File: tb/tb_msdf_mul_sequencer.sv
module tb_msdf_mul_sequencer;

    logic clk;
    logic rst;

    msdf_mul_sequencer_if #(.CW(4)) ifa ();
    msdf_mul_sequencer_if #(.CW(3)) ifb ();

    msdf_mul_sequencer #(.N(9), .DELTA(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    msdf_mul_sequencer #(.N(4), .DELTA(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       clr;
        logic       wc;
        logic       ws;
        logic       pj;
        logic       req;
        logic       rdy;
        logic [7:0] idx;
        logic       done;
    } obs_t;

    typedef struct packed {
        logic iv;
        logic st;
        obs_t o;
    } step_t;

    step_t exp_q[$];
    int checks;
    int passed;

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = ifa.busy;        o.clr = ifa.clear_regs;
            o.wc   = ifa.load_REG_WC; o.ws  = ifa.load_REG_WS;
            o.pj   = ifa.load_PJ;     o.req = ifa.digit_req;
            o.rdy  = ifa.ready_Zj;    o.idx = 8'(ifa.digit_idx);
            o.done = ifa.done;
        end else begin
            o.busy = ifb.busy;        o.clr = ifb.clear_regs;
            o.wc   = ifb.load_REG_WC; o.ws  = ifb.load_REG_WS;
            o.pj   = ifb.load_PJ;     o.req = ifb.digit_req;
            o.rdy  = ifb.ready_Zj;    o.idx = 8'(ifb.digit_idx);
            o.done = ifb.done;
        end
        return o;
    endfunction

    task automatic set_in(input int sel, input logic st, input logic iv);
        if (sel == 0) begin
            ifa.start = st; ifa.in_valid = iv;
        end else begin
            ifb.start = st; ifb.in_valid = iv;
        end
    endtask

    // Build the expected cycle-by-cycle timeline of one run: INIT, RUN (with
    // any stall cycles), DONE and one trailing IDLE cycle.
    task automatic push_run(input int n, input int d, input int stall_cnt, input int stall_len,
                            input int drop_cnt, input int drop_len, input bit spurious);
        step_t e;
        int    rc;
        logic  iv_c;
        rc = 0;
        e = '0; e.iv = 1'b1; e.o.busy = 1'b1; e.o.clr = 1'b1;
        exp_q.push_back(e);
        for (int c = 0; c < n + d; c++) begin
`ifdef MSDF_STALL_EN
            if (c == stall_cnt && c < n) begin
                for (int k = 0; k < stall_len; k++) begin
                    e = '0; e.iv = 1'b0; e.o.busy = 1'b1;
                    e.st = spurious && (rc == 2 || rc == 11);
                    exp_q.push_back(e);
                    rc++;
                end
            end
            iv_c = !(c >= drop_cnt && c < drop_cnt + drop_len && drop_len > 0);
`else
            iv_c = !((c >= stall_cnt && c < stall_cnt + stall_len && stall_len > 0) ||
                     (c >= drop_cnt && c < drop_cnt + drop_len && drop_len > 0));
`endif
            e = '0;
            e.iv = iv_c;
            e.st = spurious && (rc == 2 || rc == 11);
            e.o.busy = 1'b1; e.o.wc = 1'b1; e.o.ws = 1'b1;
            e.o.pj  = (c < n);
            e.o.req = (c < n);
            e.o.rdy = (c >= d);
            e.o.idx = (c >= d) ? 8'(c - d) : 8'd0;
            exp_q.push_back(e);
            rc++;
        end
        e = '0; e.iv = 1'b1; e.st = spurious; e.o.busy = 1'b1; e.o.done = 1'b1;
        exp_q.push_back(e);
        e = '0; e.iv = 1'b1;
        exp_q.push_back(e);
    endtask

    // Called #1 after an edge with the selected DUT idle.
    task automatic check_run(input string name, input int sel, input int n, input int d,
                             input int stall_cnt, input int stall_len,
                             input int drop_cnt, input int drop_len, input bit spurious);
        step_t e;
        obs_t  act;
        int    cyc;
        push_run(n, d, stall_cnt, stall_len, drop_cnt, drop_len, spurious);
        set_in(sel, 1'b1, 1'b1);
        @(posedge clk); #1;
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            set_in(sel, e.st, e.iv);
            @(negedge clk);
            act = sample(sel);
            checks++;
            if (act !== e.o)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, e.o);
            else
                passed++;
            @(posedge clk); #1;
            cyc++;
        end
        set_in(sel, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        obs_t act;
        rst = 1'b0;
        set_in(0, 1'b1, 1'b1);
        set_in(1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            act = sample(s);
            checks++;
            if (act !== '0) $display("FAIL reset_outputs dut%0d: got %h expected 0", s, act);
            else passed++;
        end
        set_in(0, 1'b0, 1'b1);
        set_in(1, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        act = sample(0);
        checks++;
        if (act !== '0) $display("FAIL reset_idle_after_release: got %h expected 0", act);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_run();
        check_run("basic_run", 0, 9, 3, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        obs_t act;
        check_run("start_while_busy", 0, 9, 3, -1, 0, -1, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            act = sample(0);
            checks++;
            if (act !== '0) $display("FAIL no_restart_idle: got %h expected 0", act);
            else passed++;
            @(posedge clk); #1;
        end
        check_run("run_after_ignore", 0, 9, 3, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        obs_t act;
        obs_t exp;
        set_in(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #3;
        exp = '0; exp.busy = 1'b1; exp.wc = 1'b1; exp.ws = 1'b1;
        exp.pj = 1'b1; exp.req = 1'b1; exp.rdy = 1'b1; exp.idx = 8'd2;
        act = sample(0);
        checks++;
        if (act !== exp) $display("FAIL run_cnt5_before_reset: got %h expected %h", act, exp);
        else passed++;
        rst = 1'b0;
        #1;
        act = sample(0);
        checks++;
        if (act !== '0) $display("FAIL async_reset_immediate: got %h expected 0", act);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_run("run_after_reset", 0, 9, 3, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        check_run("stall", 0, 9, 3, 2, 3, 10, 2, 1'b0);
    endtask

    task automatic test_params();
        check_run("n4_d2", 1, 4, 2, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        obs_t act;
        int clr_cyc[$];
        int done_cyc[$];
        int first_clr;
        int second_clr;
        int first_done;
        int second_done;
        set_in(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            act = sample(0);
            if (act.clr === 1'b1) clr_cyc.push_back(cyc);
            if (act.done === 1'b1) done_cyc.push_back(cyc);
            if (cyc == 30) set_in(0, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        checks++;
        if (clr_cyc.size() != 2 || done_cyc.size() != 2) begin
            $display("FAIL b2b_counts: got clears=%0d dones=%0d expected 2 and 2",
                     clr_cyc.size(), done_cyc.size());
        end else begin
            passed++;
        end
        first_clr   = (clr_cyc.size() > 0)  ? clr_cyc[0]  : -1;
        second_clr  = (clr_cyc.size() > 1)  ? clr_cyc[1]  : -1;
        first_done  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
        second_done = (done_cyc.size() > 1) ? done_cyc[1] : -1;
        checks++;
        if (first_clr != 1 || second_clr != 16)
            $display("FAIL b2b_init_spacing: got %0d,%0d expected 1,16", first_clr, second_clr);
        else passed++;
        checks++;
        if (first_done != 14 || second_done != 29)
            $display("FAIL b2b_done_cycles: got %0d,%0d expected 14,29", first_done, second_done);
        else passed++;
        @(negedge clk);
        act = sample(0);
        checks++;
        if (act !== '0) $display("FAIL b2b_idle_after: got %h expected 0", act);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        ifa.start = 1'b0; ifa.in_valid = 1'b1;
        ifb.start = 1'b0; ifb.in_valid = 1'b1;
        rst = 1'b0;
        #2;
        test_reset();
        test_basic_run();
        test_start_while_busy();
        test_async_reset();
        test_stall();
        test_params();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
